// File: rtl/error_tolerant_key_loader32.sv
// Serial key loader: shifts in KEY_W bits LSB first plus an even-parity bit,
// commits the key to keyinput_o only when parity checks, otherwise flags an error.
module error_tolerant_key_loader32 #(
    parameter int unsigned KEY_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             key_start_i,
    input  logic             key_svalid_i,
    input  logic             key_sdata_i,
    input  logic             key_clear_i,
    output logic [KEY_W-1:0] keyinput_o,
    output logic             key_valid_o,
    output logic             key_busy_o,
    output logic             key_done_o,
    output logic             key_err_o
);

    localparam int unsigned CNT_W = $clog2(KEY_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_CHECK
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [KEY_W-1:0] shreg_q, shreg_d;
    logic [KEY_W-1:0] key_d;
    logic             par_q, par_d;
    logic             valid_d, done_d, err_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q       <= '0;
            shreg_q     <= '0;
            par_q       <= 1'b0;
            keyinput_o  <= '0;
            key_valid_o <= 1'b0;
            key_done_o  <= 1'b0;
            key_err_o   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            par_q       <= par_d;
            keyinput_o  <= key_d;
            key_valid_o <= valid_d;
            key_done_o  <= done_d;
            key_err_o   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        key_d   = keyinput_o;
        valid_d = key_valid_o;
        done_d  = 1'b0;
        err_d   = key_err_o;

        if (key_clear_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            shreg_d = '0;
            key_d   = '0;
            valid_d = 1'b0;
            err_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (key_start_i) begin
                        state_d = ST_SHIFT;
                        cnt_d   = '0;
                        shreg_d = '0;
                        err_d   = 1'b0;
                    end
                end
                ST_SHIFT: begin
                    // A restart wins over a data bit presented in the same cycle.
                    if (key_start_i) begin
                        cnt_d   = '0;
                        shreg_d = '0;
                        err_d   = 1'b0;
                    end else if (key_svalid_i) begin
                        if (cnt_q == CNT_W'(KEY_W)) begin
                            par_d   = key_sdata_i;
                            state_d = ST_CHECK;
                        end else begin
                            shreg_d = shreg_q | (KEY_W'(key_sdata_i) << cnt_q);
                            cnt_d   = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_CHECK: begin
                    state_d = ST_IDLE;
                    if ((^shreg_q ^ par_q) == 1'b0) begin
                        key_d   = shreg_q;
                        valid_d = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign key_busy_o = (state_q == ST_SHIFT) || (state_q == ST_CHECK);

endmodule

// File: tb/tb_error_tolerant_key_loader32.sv
// Directed bench for error_tolerant_key_loader32: table of full loads plus
// hand-written restart, reset, clear and same-cycle corner sequences.
module tb_error_tolerant_key_loader32;

    logic        clk_i;
    logic        rst_ni;
    logic        key_start_i;
    logic        key_svalid_i;
    logic        key_sdata_i;
    logic        key_clear_i;
    logic [31:0] keyinput_o;
    logic        key_valid_o;
    logic        key_busy_o;
    logic        key_done_o;
    logic        key_err_o;

    int n_tests = 0;
    int n_fail  = 0;

    error_tolerant_key_loader32 #(.KEY_W(32)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .key_start_i  (key_start_i),
        .key_svalid_i (key_svalid_i),
        .key_sdata_i  (key_sdata_i),
        .key_clear_i  (key_clear_i),
        .keyinput_o   (keyinput_o),
        .key_valid_o  (key_valid_o),
        .key_busy_o   (key_busy_o),
        .key_done_o   (key_done_o),
        .key_err_o    (key_err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] key;
        logic        par;
        bit          gaps;
        logic [31:0] exp_key;
        logic        exp_valid;
        logic        exp_err;
        logic        exp_done;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic start_pulse();
        key_start_i = 1'b1;
        tick();
        key_start_i = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] val, input int nbits, input bit gaps);
        for (int i = 0; i < nbits; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                key_svalid_i = 1'b0;
                repeat ($urandom_range(1, 3)) tick();
            end
            key_svalid_i = 1'b1;
            key_sdata_i  = val[i];
            tick();
        end
        key_svalid_i = 1'b0;
        key_sdata_i  = 1'b0;
    endtask

    task automatic finish_load(input logic par, input bit start_in_check,
                               input logic [31:0] exp_key, input logic exp_valid,
                               input logic exp_err, input logic exp_done, input string name);
        key_svalid_i = 1'b1;
        key_sdata_i  = par;
        tick();
        key_svalid_i = 1'b0;
        key_sdata_i  = 1'b0;
        chk1({name, " busy_in_check"}, key_busy_o, 1'b1);
        chk1({name, " done_early"}, key_done_o, 1'b0);
        key_start_i = start_in_check;
        tick();
        key_start_i = 1'b0;
        chk32({name, " key"}, keyinput_o, exp_key);
        chk1({name, " valid"}, key_valid_o, exp_valid);
        chk1({name, " err"}, key_err_o, exp_err);
        chk1({name, " done"}, key_done_o, exp_done);
        chk1({name, " busy_after"}, key_busy_o, 1'b0);
        tick();
        chk1({name, " done_one_cycle"}, key_done_o, 1'b0);
    endtask

    task automatic run_load(input logic [31:0] key, input logic par, input bit gaps,
                            input logic [31:0] prev_key, input logic [31:0] exp_key,
                            input logic exp_valid, input logic exp_err,
                            input logic exp_done, input string name);
        start_pulse();
        chk1({name, " busy_shift"}, key_busy_o, 1'b1);
        send_bits(key, 32, gaps);
        chk32({name, " key_held"}, keyinput_o, prev_key);
        finish_load(par, 1'b0, exp_key, exp_valid, exp_err, exp_done, name);
    endtask

    initial begin
        logic [31:0] cur_key;

        vecs[0] = '{32'hA5A50F0F, 1'b0, 1'b0, 32'hA5A50F0F, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{32'h00000001, 1'b0, 1'b0, 32'hA5A50F0F, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{32'h12345678, 1'b1, 1'b1, 32'h12345678, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{32'h80000000, 1'b1, 1'b0, 32'h80000000, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{32'hFFFFFFFF, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{32'h00000003, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0};

        rst_ni       = 1'b0;
        key_start_i  = 1'b0;
        key_svalid_i = 1'b0;
        key_sdata_i  = 1'b0;
        key_clear_i  = 1'b0;
        cur_key      = 32'h0;

        repeat (2) tick();
        chk32("reset key", keyinput_o, 32'h0);
        chk1("reset valid", key_valid_o, 1'b0);
        chk1("reset busy", key_busy_o, 1'b0);
        chk1("reset done", key_done_o, 1'b0);
        chk1("reset err", key_err_o, 1'b0);
        #2 rst_ni = 1'b1;

        for (int v = 0; v < 6; v++) begin
            run_load(vecs[v].key, vecs[v].par, vecs[v].gaps, cur_key, vecs[v].exp_key,
                     vecs[v].exp_valid, vecs[v].exp_err, vecs[v].exp_done,
                     $sformatf("vec%0d", v));
            cur_key = vecs[v].exp_key;
        end

        // Gapped partial load, restart with a simultaneous data bit, full reload.
        start_pulse();
        chk1("restart err_cleared", key_err_o, 1'b0);
        send_bits(32'hFFFFFFFF, 10, 1'b1);
        chk32("restart key_held", keyinput_o, 32'hFFFFFFFF);
        key_start_i  = 1'b1;
        key_svalid_i = 1'b1;
        key_sdata_i  = 1'b1;
        tick();
        key_start_i  = 1'b0;
        key_svalid_i = 1'b0;
        key_sdata_i  = 1'b0;
        send_bits(32'h12345678, 32, 1'b1);
        chk32("restart key_held2", keyinput_o, 32'hFFFFFFFF);
        finish_load(1'b1, 1'b1, 32'h12345678, 1'b1, 1'b0, 1'b1, "restart");

        // Start with a valid data bit in IDLE: the bit must not be stored.
        key_start_i  = 1'b1;
        key_svalid_i = 1'b1;
        key_sdata_i  = 1'b1;
        tick();
        key_start_i  = 1'b0;
        key_svalid_i = 1'b0;
        key_sdata_i  = 1'b0;
        send_bits(32'h00000000, 32, 1'b0);
        finish_load(1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, "samecycle");

        // Asynchronous reset in the middle of a load.
        run_load(32'h12345678, 1'b1, 1'b0, 32'h0, 32'h12345678, 1'b1, 1'b0, 1'b1, "preload");
        start_pulse();
        send_bits(32'hFFFFFFFF, 20, 1'b0);
        rst_ni = 1'b0;
        #2;
        chk32("midrst key", keyinput_o, 32'h0);
        chk1("midrst valid", key_valid_o, 1'b0);
        chk1("midrst busy", key_busy_o, 1'b0);
        chk1("midrst done", key_done_o, 1'b0);
        chk1("midrst err", key_err_o, 1'b0);
        tick();
        #2 rst_ni = 1'b1;
        run_load(32'h80000000, 1'b1, 1'b0, 32'h0, 32'h80000000, 1'b1, 1'b0, 1'b1, "postrst");

        // Clear while shifting with a committed key.
        run_load(32'h12345678, 1'b1, 1'b0, 32'h80000000, 32'h12345678, 1'b1, 1'b0, 1'b1, "preclr");
        start_pulse();
        send_bits(32'h0000001F, 5, 1'b0);
        key_clear_i = 1'b1;
        tick();
        key_clear_i = 1'b0;
        chk32("clear key", keyinput_o, 32'h0);
        chk1("clear valid", key_valid_o, 1'b0);
        chk1("clear busy", key_busy_o, 1'b0);
        chk1("clear done", key_done_o, 1'b0);

        // Clear removes a sticky parity error.
        run_load(32'h00000001, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, "errload");
        tick();
        chk1("err sticky", key_err_o, 1'b1);
        key_clear_i = 1'b1;
        tick();
        key_clear_i = 1'b0;
        chk1("clear err", key_err_o, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
